auction_ctrl_n: RTL and testbench

AUCTION_CTRL_N -- requirements
Module: auction_ctrl_n

---
 rtl/auction_ctrl_n_if.sv | 43 ++++
 rtl/auction_ctrl_n.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_auction_ctrl_n.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/auction_ctrl_n_if.sv
`default_nettype none
// ============================================================================
// Module   : auction_ctrl_n_if
// Purpose  : Command / bidder bus of the auction controller.
//            slave  modport : seen by the controller.
//            master modport : seen by the host and bidders.
// Signals  : c_op, c_data, c_start   command channel (host -> controller)
//            bid, bid_amt, retract   per-bidder request channel
//            ready, c_err, round_over, max_bid, win   status to host
//            ack, b_err, balance     per-bidder status
// Revision : 1.0  initial release
// ============================================================================
interface auction_ctrl_n_if #(
    parameter int NUM_BIDDERS = 3,
    parameter int DATA_W      = 32
);
    logic [3:0]                    c_op;
    logic [DATA_W-1:0]             c_data;
    logic                          c_start;
    logic [NUM_BIDDERS-1:0]        bid;
    logic [NUM_BIDDERS*DATA_W-1:0] bid_amt;
    logic [NUM_BIDDERS-1:0]        retract;

    logic                          ready;
    logic [2:0]                    c_err;
    logic                          round_over;
    logic [DATA_W-1:0]             max_bid;
    logic [NUM_BIDDERS-1:0]        ack;
    logic [NUM_BIDDERS*2-1:0]      b_err;
    logic [NUM_BIDDERS-1:0]        win;
    logic [NUM_BIDDERS*DATA_W-1:0] balance;

    modport slave (
        input  c_op, c_data, c_start, bid, bid_amt, retract,
        output ready, c_err, round_over, max_bid, ack, b_err, win, balance
    );

    modport master (
        output c_op, c_data, c_start, bid, bid_amt, retract,
        input  ready, c_err, round_over, max_bid, ack, b_err, win, balance
    );
endinterface
`default_nettype wire

// File: rtl/auction_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : auction_ctrl_n
// Purpose  : Sealed-round auction controller. A host configures balances,
//            bidder mask, cooldown timer and per-bid charge while unlocked,
//            locks with a key, then runs rounds: bidders raise the leading
//            bid, the winner pays its bid when the round closes.
// Ports    : clk      clock
//            reset_n  asynchronous active-low reset
//            bus      auction_ctrl_n_if.slave (command, bids, status)
// Options  : AUCTION_RETRACT_EN - when defined, retract[i] withdraws bidder
//            i's standing bid during a round; otherwise retract is ignored.
// Revision : 1.0  initial release
// ============================================================================
module auction_ctrl_n #(
    parameter int NUM_BIDDERS = 3,
    parameter int DATA_W      = 32
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    auction_ctrl_n_if.slave     bus
);
    localparam int IDX_W = $clog2(NUM_BIDDERS);
    localparam logic [DATA_W-1:0] C_NB = DATA_W'(NUM_BIDDERS);

    localparam logic [3:0] C_OP_NOOP      = 4'd0;
    localparam logic [3:0] C_OP_UNLOCK    = 4'd1;
    localparam logic [3:0] C_OP_LOCK      = 4'd2;
    localparam logic [3:0] C_OP_SELECT    = 4'd3;
    localparam logic [3:0] C_OP_LOAD      = 4'd4;
    localparam logic [3:0] C_OP_SETMASK   = 4'd5;
    localparam logic [3:0] C_OP_SETTIMER  = 4'd6;
    localparam logic [3:0] C_OP_SETCHARGE = 4'd7;

    localparam logic [2:0] C_ERR_NONE      = 3'd0;
    localparam logic [2:0] C_ERR_CSTART    = 3'd1;
    localparam logic [2:0] C_ERR_UNLOCKED  = 3'd2;
    localparam logic [2:0] C_ERR_BADKEY    = 3'd3;
    localparam logic [2:0] C_ERR_INVALIDOP = 3'd4;
    localparam logic [2:0] C_ERR_DUPBIDS   = 3'd5;

    localparam logic [1:0] C_BERR_INACTIVE = 2'd1;
    localparam logic [1:0] C_BERR_FUNDS    = 2'd2;
    localparam logic [1:0] C_BERR_REJECTED = 2'd3;

    typedef enum logic [2:0] {
        ST_UNLOCKED = 3'd0,
        ST_LOCKED   = 3'd1,
        ST_COOLDOWN = 3'd2,
        ST_ROUND    = 3'd3,
        ST_DECIDE   = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t                                 state_q, state_d;
    logic [DATA_W-1:0]                      key_q, key_d;
    logic [DATA_W-1:0]                      timer_q, timer_d;
    logic [DATA_W-1:0]                      charge_q, charge_d;
    logic [DATA_W-1:0]                      max_bid_q, max_bid_d;
    logic [DATA_W-1:0]                      cd_cnt_q, cd_cnt_d;
    logic [IDX_W-1:0]                       sel_q, sel_d;
    logic [IDX_W-1:0]                       leader_q, leader_d;
    logic                                   has_leader_q, has_leader_d;
    logic [NUM_BIDDERS-1:0]                 mask_q, mask_d;
    logic [NUM_BIDDERS-1:0]                 ack_q, ack_d;
    logic [NUM_BIDDERS*2-1:0]               b_err_q, b_err_d;
    logic [2:0]                             c_err_q, c_err_d;
    logic [NUM_BIDDERS-1:0][DATA_W-1:0]     balance_q, balance_d;
    logic [NUM_BIDDERS-1:0][DATA_W-1:0]     lastbid_q, lastbid_d;

    // Per-bidder qualification of this cycle's bids.
    logic [NUM_BIDDERS-1:0][DATA_W-1:0]     amt;
    logic [NUM_BIDDERS-1:0]                 funds_ok, above_max, eligible, dup;
    logic [DATA_W-1:0]                      top_amt;
    logic [IDX_W-1:0]                       top_idx;
    logic                                   top_valid;
    logic [NUM_BIDDERS-1:0]                 win_w;

    assign amt = bus.bid_amt;

    always_comb begin : p_bid_eval
        funds_ok  = '0;
        above_max = '0;
        eligible  = '0;
        dup       = '0;
        top_amt   = '0;
        top_idx   = '0;
        top_valid = 1'b0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            // Extra bit keeps amount + charge from wrapping past the balance.
            funds_ok[i]  = ({1'b0, amt[i]} + {1'b0, charge_q}) <= {1'b0, balance_q[i]};
            above_max[i] = amt[i] > max_bid_q;
            eligible[i]  = bus.bid[i] & mask_q[i] & funds_ok[i] & above_max[i];
            // Strict compare while scanning upward: ties go to the lowest index.
            if (eligible[i] && (!top_valid || amt[i] > top_amt)) begin
                top_valid = 1'b1;
                top_amt   = amt[i];
                top_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            dup[i] = eligible[i] && (amt[i] == top_amt) && (IDX_W'(i) != top_idx);
        end
    end

    always_comb begin : p_next
        state_d      = state_q;
        key_d        = key_q;
        timer_d      = timer_q;
        charge_d     = charge_q;
        max_bid_d    = max_bid_q;
        cd_cnt_d     = cd_cnt_q;
        sel_d        = sel_q;
        leader_d     = leader_q;
        has_leader_d = has_leader_q;
        mask_d       = mask_q;
        balance_d    = balance_q;
        lastbid_d    = lastbid_q;
        ack_d        = '0;
        b_err_d      = '0;
        c_err_d      = C_ERR_NONE;

        case (state_q)
            ST_UNLOCKED: begin
                if (bus.c_start) begin
                    c_err_d = C_ERR_CSTART;
                end else begin
                    case (bus.c_op)
                        C_OP_NOOP:      ;
                        C_OP_UNLOCK:    c_err_d = C_ERR_UNLOCKED;
                        C_OP_LOCK: begin
                            key_d   = bus.c_data;
                            state_d = ST_LOCKED;
                        end
                        C_OP_SELECT:    sel_d = IDX_W'(bus.c_data % C_NB);
                        C_OP_LOAD:      balance_d[sel_q] = bus.c_data;
                        C_OP_SETMASK:   mask_d = bus.c_data[NUM_BIDDERS-1:0];
                        C_OP_SETTIMER:  timer_d = bus.c_data;
                        C_OP_SETCHARGE: charge_d = bus.c_data;
                        default:        c_err_d = C_ERR_INVALIDOP;
                    endcase
                end
            end

            ST_LOCKED: begin
                if (bus.c_start) begin
                    state_d = ST_ROUND;
                end else if (bus.c_op == C_OP_UNLOCK) begin
                    if (bus.c_data == key_q) begin
                        state_d = ST_UNLOCKED;
                    end else begin
                        // c_err is registered, so raise it on entry to line up
                        // exactly with the cycles spent in COOLDOWN.
                        state_d  = ST_COOLDOWN;
                        cd_cnt_d = (timer_q == '0) ? DATA_W'(1) : timer_q;
                        c_err_d  = C_ERR_BADKEY;
                    end
                end
            end

            ST_COOLDOWN: begin
                if (cd_cnt_q <= DATA_W'(1)) begin
                    state_d = ST_LOCKED;
                end else begin
                    cd_cnt_d = cd_cnt_q - DATA_W'(1);
                    c_err_d  = C_ERR_BADKEY;
                end
            end

            ST_ROUND: begin
                if (!bus.c_start) begin
                    state_d = ST_DECIDE;
                end else begin
`ifdef AUCTION_RETRACT_EN
                    // Withdrawals first; a same-cycle bid from the same
                    // bidder then overwrites the cleared entry.
                    for (int i = 0; i < NUM_BIDDERS; i++) begin
                        if (bus.retract[i]) begin
                            lastbid_d[i] = '0;
                        end
                    end
`endif
                    for (int i = 0; i < NUM_BIDDERS; i++) begin
                        if (bus.bid[i]) begin
                            if (!mask_q[i]) begin
                                b_err_d[2*i +: 2] = C_BERR_REJECTED;
                            end else if (!funds_ok[i]) begin
                                b_err_d[2*i +: 2] = C_BERR_FUNDS;
                            end else if (!above_max[i] || dup[i]) begin
                                b_err_d[2*i +: 2] = C_BERR_REJECTED;
                            end else begin
                                ack_d[i]     = 1'b1;
                                balance_d[i] = balance_q[i] - charge_q;
                                lastbid_d[i] = amt[i];
                            end
                        end
                    end
                    if (|dup) begin
                        c_err_d = C_ERR_DUPBIDS;
                    end
                    if (top_valid) begin
                        leader_d     = top_idx;
                        max_bid_d    = top_amt;
                        has_leader_d = 1'b1;
                    end
`ifdef AUCTION_RETRACT_EN
                    else if (has_leader_q && bus.retract[leader_q]) begin
                        // Leader withdrew: best remaining standing bid leads.
                        max_bid_d    = '0;
                        leader_d     = '0;
                        has_leader_d = 1'b0;
                        for (int i = 0; i < NUM_BIDDERS; i++) begin
                            if (lastbid_d[i] > max_bid_d) begin
                                max_bid_d    = lastbid_d[i];
                                leader_d     = IDX_W'(i);
                                has_leader_d = 1'b1;
                            end
                        end
                    end
`endif
                end
            end

            ST_DECIDE: begin
                if (has_leader_q) begin
                    balance_d[leader_q] = balance_q[leader_q] - lastbid_q[leader_q];
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d      = ST_LOCKED;
                lastbid_d    = '0;
                leader_d     = '0;
                has_leader_d = 1'b0;
                max_bid_d    = '0;
            end

            default: state_d = ST_UNLOCKED;
        endcase

        if (state_q != ST_ROUND) begin
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                if (bus.bid[i]) begin
                    b_err_d[2*i +: 2] = C_BERR_INACTIVE;
                end
            end
        end
    end

`ifndef AUCTION_RETRACT_EN
    logic unused_retract;
    assign unused_retract = ^bus.retract;
`endif

    always_ff @(posedge clk or negedge reset_n) begin : p_regs
        if (!reset_n) begin
            state_q      <= ST_UNLOCKED;
            key_q        <= '0;
            timer_q      <= DATA_W'(15);
            charge_q     <= DATA_W'(1);
            max_bid_q    <= '0;
            cd_cnt_q     <= '0;
            sel_q        <= '0;
            leader_q     <= '0;
            has_leader_q <= 1'b0;
            mask_q       <= '1;
            ack_q        <= '0;
            b_err_q      <= '0;
            c_err_q      <= C_ERR_NONE;
            balance_q    <= '0;
            lastbid_q    <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            timer_q      <= timer_d;
            charge_q     <= charge_d;
            max_bid_q    <= max_bid_d;
            cd_cnt_q     <= cd_cnt_d;
            sel_q        <= sel_d;
            leader_q     <= leader_d;
            has_leader_q <= has_leader_d;
            mask_q       <= mask_d;
            ack_q        <= ack_d;
            b_err_q      <= b_err_d;
            c_err_q      <= c_err_d;
            balance_q    <= balance_d;
            lastbid_q    <= lastbid_d;
        end
    end

    always_comb begin : p_win
        win_w = '0;
        if (state_q == ST_DONE && has_leader_q) begin
            win_w[leader_q] = 1'b1;
        end
    end

    assign bus.ready      = !(state_q == ST_DECIDE || state_q == ST_DONE);
    assign bus.c_err      = c_err_q;
    assign bus.round_over = (state_q == ST_DONE);
    assign bus.max_bid    = max_bid_q;
    assign bus.ack        = ack_q;
    assign bus.b_err      = b_err_q;
    assign bus.win        = win_w;
    assign bus.balance    = balance_q;

endmodule
`default_nettype wire

// File: tb/tb_auction_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_auction_ctrl_n
// Purpose  : Directed, table-driven bench for auction_ctrl_n (3 bidders,
//            32-bit data) plus hand-written retract and mid-round reset
//            sequences. AUCTION_RETRACT_EN selects the retract expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_auction_ctrl_n;
    localparam int N = 3;
    localparam int W = 32;

    localparam logic [3:0] NOP = 4'd0, UNLK = 4'd1, LOCK = 4'd2, SEL = 4'd3;
    localparam logic [3:0] LOAD = 4'd4, SETM = 4'd5, SETT = 4'd6;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    auction_ctrl_n_if #(.NUM_BIDDERS(N), .DATA_W(W)) bus_if ();

    auction_ctrl_n #(.NUM_BIDDERS(N), .DATA_W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] data;
        logic         st;
        logic [N-1:0] bid;
        logic [W-1:0] a0, a1, a2;
        logic         e_rdy;
        logic [2:0]   e_cerr;
        logic [5:0]   e_berr;
        logic [N-1:0] e_ack;
        logic         e_ro;
        logic [N-1:0] e_win;
        logic [W-1:0] e_max;
        logic [W-1:0] e_b0, e_b1, e_b2;
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [W-1:0] data, input logic st,
                       input logic [N-1:0] bid, input logic [W-1:0] a0, a1, a2,
                       input logic rdy, input logic [2:0] ce, input logic [5:0] be,
                       input logic [N-1:0] ack, input logic ro, input logic [N-1:0] win,
                       input logic [W-1:0] mx, input logic [W-1:0] b0, b1, b2);
        vec_t v;
        v.op = op; v.data = data; v.st = st; v.bid = bid;
        v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.e_rdy = rdy; v.e_cerr = ce; v.e_berr = be; v.e_ack = ack;
        v.e_ro = ro; v.e_win = win; v.e_max = mx;
        v.e_b0 = b0; v.e_b1 = b1; v.e_b2 = b2;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then sample #1 after the active edge.
    task automatic cyc(input logic [3:0] op, input logic [W-1:0] data, input logic st,
                       input logic [N-1:0] bid, input logic [W-1:0] a0, a1, a2,
                       input logic [N-1:0] ret);
        bus_if.c_op    = op;
        bus_if.c_data  = data;
        bus_if.c_start = st;
        bus_if.bid     = bid;
        bus_if.bid_amt = {a2, a1, a0};
        bus_if.retract = ret;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(NOP, 0, 0, 0, 0, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    function automatic logic [W-1:0] bal(input int i);
        logic [N*W-1:0] b;
        b = bus_if.balance;
        return b[i*W +: W];
    endfunction

    initial begin
        reset_n = 1'b0;
        bus_if.c_op = '0; bus_if.c_data = '0; bus_if.c_start = 1'b0;
        bus_if.bid = '0; bus_if.bid_amt = '0; bus_if.retract = '0;

        //   op    data  st bid   a0  a1   a2   rdy ce be         ack     ro win     max  bal0 bal1 bal2
        add(SEL,  0,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   0,   0,   0);
        add(LOAD, 100,  0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 0,   0);
        add(SEL,  4,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 0,   0);
        add(LOAD, 100,  0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 0);
        add(SEL,  2,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 0);
        add(LOAD, 100,  0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(UNLK, 0,    0, 3'b000, 0,  0,   0,  1, 2, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(4'd9, 0,    0, 3'b000, 0,  0,   0,  1, 4, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(LOAD, 5,    1, 3'b000, 0,  0,   0,  1, 1, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(NOP,  0,    0, 3'b001, 5,  0,   0,  1, 0, 6'b000001, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(SETT, 3,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(LOCK, 'h55, 0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(UNLK, 'h54, 0, 3'b000, 0,  0,   0,  1, 3, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  1, 3, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(UNLK, 'h55, 0, 3'b000, 0,  0,   0,  1, 3, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(LOAD, 7,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(NOP,  0,    1, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   100, 100, 100);
        add(NOP,  0,    1, 3'b101, 10, 0,   20, 1, 0, 6'b000000, 3'b101, 0, 3'b000, 20,  99,  100, 99);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  0, 0, 6'b000000, 3'b000, 0, 3'b000, 20,  99,  100, 99);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  0, 0, 6'b000000, 3'b000, 1, 3'b100, 20,  99,  100, 79);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  100, 79);
        add(NOP,  0,    1, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  100, 79);
        add(NOP,  0,    1, 3'b110, 0,  30,  30, 1, 5, 6'b110000, 3'b010, 0, 3'b000, 30,  99,  99,  79);
        add(NOP,  0,    1, 3'b001, 30, 0,   0,  1, 0, 6'b000011, 3'b000, 0, 3'b000, 30,  99,  99,  79);
        add(NOP,  0,    1, 3'b001, 99, 0,   0,  1, 0, 6'b000010, 3'b000, 0, 3'b000, 30,  99,  99,  79);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  0, 0, 6'b000000, 3'b000, 0, 3'b000, 30,  99,  99,  79);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  0, 0, 6'b000000, 3'b000, 1, 3'b010, 30,  99,  69,  79);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  69,  79);
        add(UNLK, 'h55, 0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  69,  79);
        add(SETM, 6,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  69,  79);
        add(SEL,  1,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  69,  79);
        add(LOAD, 100,  0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  100, 79);
        add(LOCK, 'h55, 0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  100, 79);
        add(NOP,  0,    1, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  100, 79);
        add(NOP,  0,    1, 3'b111, 5,  100, 5,  1, 0, 6'b001011, 3'b100, 0, 3'b000, 5,   99,  100, 78);
        add(NOP,  0,    1, 3'b010, 0,  99,  0,  1, 0, 6'b000000, 3'b010, 0, 3'b000, 99,  99,  99,  78);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  0, 0, 6'b000000, 3'b000, 0, 3'b000, 99,  99,  99,  78);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  0, 0, 6'b000000, 3'b000, 1, 3'b010, 99,  99,  0,   78);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  0,   78);
        add(NOP,  0,    1, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  0,   78);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  0, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  0,   78);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  0, 0, 6'b000000, 3'b000, 1, 3'b000, 0,   99,  0,   78);
        add(NOP,  0,    0, 3'b000, 0,  0,   0,  1, 0, 6'b000000, 3'b000, 0, 3'b000, 0,   99,  0,   78);

        // Reset state, checked while reset is still held.
        cyc(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("rst ready", bus_if.ready, 1);
        chk("rst c_err", bus_if.c_err, 0);
        chk("rst round_over", bus_if.round_over, 0);
        chk("rst max_bid", bus_if.max_bid, 0);
        chk("rst ack", bus_if.ack, 0);
        chk("rst balance", bus_if.balance, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            cyc(v.op, v.data, v.st, v.bid, v.a0, v.a1, v.a2, 3'b000);
            chk($sformatf("v%0d ready", i), bus_if.ready, v.e_rdy);
            chk($sformatf("v%0d c_err", i), bus_if.c_err, v.e_cerr);
            chk($sformatf("v%0d b_err", i), bus_if.b_err, v.e_berr);
            chk($sformatf("v%0d ack", i), bus_if.ack, v.e_ack);
            chk($sformatf("v%0d round_over", i), bus_if.round_over, v.e_ro);
            chk($sformatf("v%0d win", i), bus_if.win, v.e_win);
            chk($sformatf("v%0d max_bid", i), bus_if.max_bid, v.e_max);
            chk($sformatf("v%0d balance0", i), bal(0), v.e_b0);
            chk($sformatf("v%0d balance1", i), bal(1), v.e_b1);
            chk($sformatf("v%0d balance2", i), bal(2), v.e_b2);
        end

        // Retract sequence: b0 bids 10, b1 bids 20, b1 retracts.
        do_reset();
        cyc(SEL, 0, 0, 0, 0, 0, 0, 0);
        cyc(LOAD, 100, 0, 0, 0, 0, 0, 0);
        cyc(SEL, 1, 0, 0, 0, 0, 0, 0);
        cyc(LOAD, 100, 0, 0, 0, 0, 0, 0);
        cyc(LOCK, 0, 0, 0, 0, 0, 0, 0);
        cyc(NOP, 0, 1, 0, 0, 0, 0, 0);
        cyc(NOP, 0, 1, 3'b001, 10, 0, 0, 0);
        chk("ret ack0", bus_if.ack, 3'b001);
        chk("ret max10", bus_if.max_bid, 10);
        cyc(NOP, 0, 1, 3'b010, 0, 20, 0, 0);
        chk("ret max20", bus_if.max_bid, 20);
        cyc(NOP, 0, 1, 0, 0, 0, 0, 3'b010);
`ifdef AUCTION_RETRACT_EN
        chk("ret max after retract", bus_if.max_bid, 10);
`else
        chk("ret max after retract", bus_if.max_bid, 20);
`endif
        cyc(NOP, 0, 0, 0, 0, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("ret round_over", bus_if.round_over, 1);
`ifdef AUCTION_RETRACT_EN
        chk("ret win", bus_if.win, 3'b001);
        chk("ret balance0", bal(0), 89);
        chk("ret balance1", bal(1), 99);
`else
        chk("ret win", bus_if.win, 3'b010);
        chk("ret balance0", bal(0), 99);
        chk("ret balance1", bal(1), 79);
`endif
        cyc(NOP, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a round discards it.
        cyc(NOP, 0, 1, 0, 0, 0, 0, 0);
        cyc(NOP, 0, 1, 3'b001, 50, 0, 0, 0);
        chk("mid max50", bus_if.max_bid, 50);
        reset_n = 1'b0;
        #1;
        chk("mid rst max_bid", bus_if.max_bid, 0);
        chk("mid rst ready", bus_if.ready, 1);
        chk("mid rst balance0", bal(0), 0);
        cyc(NOP, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(NOP, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("mid no round_over %0d", k), bus_if.round_over, 0);
        end
        cyc(NOP, 0, 1, 0, 0, 0, 0, 0);
        chk("mid unlocked c_err", bus_if.c_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
